// File: rtl/sys_regmap.sv
// SPI-side register map: ID, scratch, control, sticky event status with interrupt, command pulse.
// Optional timestamp counter with atomic LO/HI read, enabled by defining SYS_REGMAP_TIMESTAMP_EN.
module sys_regmap #(
    parameter logic [15:0] ID_VALUE = 16'h5A01
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sys_wr_en,
    input  logic        sys_rd_en,
    input  logic [14:0] sys_addr,
    input  logic [15:0] sys_wdata,
    output logic [15:0] sys_rdata,
    input  logic [7:0]  evt_i,
    output logic [15:0] ctrl_o,
    output logic        irq_o,
    output logic        cmd_pulse_o,
    output logic [15:0] cmd_data_o
);

    localparam logic [14:0] ADDR_ID       = 15'h0000;
    localparam logic [14:0] ADDR_SCRATCH  = 15'h0001;
    localparam logic [14:0] ADDR_CTRL     = 15'h0002;
    localparam logic [14:0] ADDR_STATUS   = 15'h0003;
    localparam logic [14:0] ADDR_IRQ_MASK = 15'h0004;
    localparam logic [14:0] ADDR_TS_LO    = 15'h0005;
    localparam logic [14:0] ADDR_TS_HI    = 15'h0006;
    localparam logic [14:0] ADDR_CMD      = 15'h0007;

    logic [15:0] scratch_q;
    logic [15:0] ctrl_q;
    logic [15:0] irq_mask_q;
    logic [15:0] cmd_data_q;
    logic [15:0] rdata_q;
    logic [7:0]  evt_status_q;
    logic        addr_err_q;
    logic        irq_q;
    logic        cmd_pulse_q;

    logic        wr_acc;
    logic        rd_acc;
    logic        addr_mapped;
    logic [15:0] rd_value;
    logic [15:0] status_word;
    logic [15:0] status_clear;
    logic [7:0]  evt_status_next;
    logic        addr_err_next;

`ifdef SYS_REGMAP_TIMESTAMP_EN
    logic [31:0] ts_count;
    logic [15:0] ts_shadow_q;
`endif

    // A coincident write wins; the read strobe is dropped entirely.
    assign wr_acc = sys_wr_en;
    assign rd_acc = sys_rd_en & ~sys_wr_en;

    assign status_word = {addr_err_q, 7'b0, evt_status_q};

    always_comb begin
        addr_mapped = 1'b1;
        rd_value    = 16'h0000;
        case (sys_addr)
            ADDR_ID:       rd_value = ID_VALUE;
            ADDR_SCRATCH:  rd_value = scratch_q;
            ADDR_CTRL:     rd_value = ctrl_q;
            ADDR_STATUS:   rd_value = status_word;
            ADDR_IRQ_MASK: rd_value = irq_mask_q;
`ifdef SYS_REGMAP_TIMESTAMP_EN
            ADDR_TS_LO:    rd_value = ts_count[15:0];
            ADDR_TS_HI:    rd_value = ts_shadow_q;
`endif
            ADDR_CMD:      rd_value = 16'h0000;
            default:       addr_mapped = 1'b0;
        endcase
    end

    // Event sets take priority over a same-cycle write-one-to-clear.
    always_comb begin
        status_clear = 16'h0000;
        if (wr_acc && (sys_addr == ADDR_STATUS)) begin
            status_clear = sys_wdata;
        end
        evt_status_next = (evt_status_q & ~status_clear[7:0]) | evt_i;
        addr_err_next   = (addr_err_q & ~status_clear[15]) |
                          ((wr_acc | rd_acc) & ~addr_mapped);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scratch_q    <= 16'h0000;
            ctrl_q       <= 16'h0000;
            irq_mask_q   <= 16'h0000;
            cmd_data_q   <= 16'h0000;
            cmd_pulse_q  <= 1'b0;
            rdata_q      <= 16'h0000;
            evt_status_q <= 8'h00;
            addr_err_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            evt_status_q <= evt_status_next;
            addr_err_q   <= addr_err_next;
            irq_q        <= |(status_word & irq_mask_q);
            cmd_pulse_q  <= 1'b0;
            if (wr_acc) begin
                case (sys_addr)
                    ADDR_SCRATCH:  scratch_q  <= sys_wdata;
                    ADDR_CTRL:     ctrl_q     <= sys_wdata;
                    ADDR_IRQ_MASK: irq_mask_q <= sys_wdata;
                    ADDR_CMD: begin
                        cmd_data_q  <= sys_wdata;
                        cmd_pulse_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_acc) begin
                rdata_q <= rd_value;
            end
        end
    end

`ifdef SYS_REGMAP_TIMESTAMP_EN
    // The shadow captures the upper half in the same cycle the lower half is returned.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ts_count    <= 32'h0000_0000;
            ts_shadow_q <= 16'h0000;
        end else begin
            ts_count <= ts_count + 32'd1;
            if (rd_acc && (sys_addr == ADDR_TS_LO)) begin
                ts_shadow_q <= ts_count[31:16];
            end
        end
    end
`endif

    assign sys_rdata   = rdata_q;
    assign ctrl_o      = ctrl_q;
    assign irq_o       = irq_q;
    assign cmd_pulse_o = cmd_pulse_q;
    assign cmd_data_o  = cmd_data_q;

endmodule

// File: tb/tb_sys_regmap.sv
// Directed self-checking bench for sys_regmap; outputs are sampled on the falling clock edge.
module tb_sys_regmap;

    logic        sys_clk;
    logic        sys_rst;
    logic        sys_wr_en;
    logic        sys_rd_en;
    logic [14:0] sys_addr;
    logic [15:0] sys_wdata;
    logic [15:0] sys_rdata;
    logic [7:0]  evt_i;
    logic [15:0] ctrl_o;
    logic        irq_o;
    logic        cmd_pulse_o;
    logic [15:0] cmd_data_o;

    int passCount  = 0;
    int checkCount = 0;

    sys_regmap #(.ID_VALUE(16'h5A01)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .sys_wr_en   (sys_wr_en),
        .sys_rd_en   (sys_rd_en),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_rdata   (sys_rdata),
        .evt_i       (evt_i),
        .ctrl_o      (ctrl_o),
        .irq_o       (irq_o),
        .cmd_pulse_o (cmd_pulse_o),
        .cmd_data_o  (cmd_data_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Drive one cycle of inputs, let the rising edge sample them, return at the falling edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [14:0] addr,
                                 input logic [15:0] wdata, input logic [7:0] evt,
                                 input logic rst);
        sys_wr_en = wr;
        sys_rd_en = rd;
        sys_addr  = addr;
        sys_wdata = wdata;
        evt_i     = evt;
        sys_rst   = rst;
        @(negedge sys_clk);
        sys_wr_en = 1'b0;
        sys_rd_en = 1'b0;
        sys_addr  = 15'h0;
        sys_wdata = 16'h0;
        evt_i     = 8'h0;
        sys_rst   = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0, 8'h0, 1'b0);
    endtask

    task automatic regWrite(input logic [14:0] addr, input logic [15:0] wdata);
        applyStimulus(1'b1, 1'b0, addr, wdata, 8'h0, 1'b0);
    endtask

    task automatic regRead(input logic [14:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 16'h0, 8'h0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        sys_wr_en = 1'b0;
        sys_rd_en = 1'b0;
        sys_addr  = 15'h0;
        sys_wdata = 16'h0;
        evt_i     = 8'h0;

        // Reset held with a CMD write and all events pending: reset must win.
        applyStimulus(1'b1, 1'b0, 15'h0007, 16'hDEAD, 8'hFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 15'h0002, 16'hBEEF, 8'hFF, 1'b1);
        checkOutput("reset_rdata", sys_rdata, 32'h0);
        checkOutput("reset_ctrl", ctrl_o, 32'h0);
        checkOutput("reset_irq", irq_o, 32'h0);
        checkOutput("reset_cmd_pulse", cmd_pulse_o, 32'h0);
        checkOutput("reset_cmd_data", cmd_data_o, 32'h0);

`ifdef SYS_REGMAP_TIMESTAMP_EN
        regRead(15'h0005);
        checkOutput("ts_lo_after_reset", sys_rdata, 32'h0000);
        regRead(15'h0006);
        checkOutput("ts_hi_after_reset", sys_rdata, 32'h0000);
`endif

        regRead(15'h0003);
        checkOutput("status_after_reset", sys_rdata, 32'h0000);

        regRead(15'h0000);
        checkOutput("id_read", sys_rdata, 32'h5A01);
        repeat (4) idle();
        checkOutput("id_read_held", sys_rdata, 32'h5A01);

        regWrite(15'h0002, 16'h1234);
        checkOutput("ctrl_o_after_write", ctrl_o, 32'h1234);
        regRead(15'h0002);
        checkOutput("ctrl_readback", sys_rdata, 32'h1234);

        regWrite(15'h0000, 16'hFFFF);
        regRead(15'h0000);
        checkOutput("id_write_ignored", sys_rdata, 32'h5A01);
        regRead(15'h0003);
        checkOutput("id_write_no_err", sys_rdata, 32'h0000);

        regWrite(15'h0001, 16'hA5A5);
        regRead(15'h0001);
        checkOutput("scratch_readback", sys_rdata, 32'hA5A5);

        regWrite(15'h0004, 16'h0004);
        regRead(15'h0004);
        checkOutput("irq_mask_readback", sys_rdata, 32'h0004);

        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0, 8'h04, 1'b0);
        checkOutput("irq_lags_status", irq_o, 32'h0);
        idle();
        checkOutput("irq_set", irq_o, 32'h1);
        regRead(15'h0003);
        checkOutput("status_evt2", sys_rdata, 32'h0004);

        applyStimulus(1'b1, 1'b0, 15'h0003, 16'h0004, 8'h04, 1'b0);
        regRead(15'h0003);
        checkOutput("set_beats_clear", sys_rdata, 32'h0004);
        checkOutput("irq_still_set", irq_o, 32'h1);

        regWrite(15'h0003, 16'h0004);
        idle();
        checkOutput("irq_cleared", irq_o, 32'h0);
        regRead(15'h0003);
        checkOutput("status_cleared", sys_rdata, 32'h0000);

        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0, 8'h20, 1'b0);
        idle();
        checkOutput("irq_masked_evt5", irq_o, 32'h0);
        regRead(15'h0003);
        checkOutput("status_evt5", sys_rdata, 32'h0020);
        regWrite(15'h0003, 16'h00FF);

        regRead(15'h7FFF);
        checkOutput("unmapped_read_zero", sys_rdata, 32'h0000);
        regRead(15'h0003);
        checkOutput("addr_err_set", sys_rdata, 32'h8000);
        regWrite(15'h0003, 16'h8000);
        regRead(15'h0003);
        checkOutput("addr_err_cleared", sys_rdata, 32'h0000);

        regWrite(15'h0007, 16'hBEEF);
        checkOutput("cmd_pulse", cmd_pulse_o, 32'h1);
        checkOutput("cmd_data", cmd_data_o, 32'hBEEF);
        idle();
        checkOutput("cmd_pulse_one_cycle", cmd_pulse_o, 32'h0);
        checkOutput("cmd_data_held", cmd_data_o, 32'hBEEF);
        regWrite(15'h0007, 16'h1111);
        checkOutput("cmd_b2b_pulse1", cmd_pulse_o, 32'h1);
        checkOutput("cmd_b2b_data1", cmd_data_o, 32'h1111);
        regWrite(15'h0007, 16'h2222);
        checkOutput("cmd_b2b_pulse2", cmd_pulse_o, 32'h1);
        checkOutput("cmd_b2b_data2", cmd_data_o, 32'h2222);
        regRead(15'h0007);
        checkOutput("cmd_reads_zero", sys_rdata, 32'h0000);

        regRead(15'h0000);
        applyStimulus(1'b1, 1'b1, 15'h0001, 16'h0F0F, 8'h0, 1'b0);
        checkOutput("wr_rd_rdata_held", sys_rdata, 32'h5A01);
        regRead(15'h0001);
        checkOutput("wr_rd_write_done", sys_rdata, 32'h0F0F);

`ifdef SYS_REGMAP_TIMESTAMP_EN
        force dut.ts_count = 32'h0001_FFFE;
        regRead(15'h0005);
        release dut.ts_count;
        checkOutput("ts_lo_before_carry", sys_rdata, 32'hFFFE);
        repeat (3) idle();
        regRead(15'h0006);
        checkOutput("ts_hi_shadow", sys_rdata, 32'h0001);
        regRead(15'h0006);
        checkOutput("ts_hi_reread", sys_rdata, 32'h0001);

        force dut.ts_count = 32'hFFFF_FFFF;
        regRead(15'h0005);
        release dut.ts_count;
        checkOutput("ts_lo_at_wrap", sys_rdata, 32'hFFFF);
        repeat (2) idle();
        regRead(15'h0006);
        checkOutput("ts_hi_after_wrap", sys_rdata, 32'hFFFF);
`else
        regRead(15'h0005);
        checkOutput("ts_lo_unmapped", sys_rdata, 32'h0000);
        regRead(15'h0003);
        checkOutput("ts_lo_addr_err", sys_rdata, 32'h8000);
        regWrite(15'h0003, 16'h8000);
        regRead(15'h0006);
        checkOutput("ts_hi_unmapped", sys_rdata, 32'h0000);
        regWrite(15'h0003, 16'h8000);
`endif

        // Reset arriving together with a CMD write, an event and a read.
        regWrite(15'h0004, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 15'h0007, 16'h5555, 8'hFF, 1'b1);
        checkOutput("rst_mid_cmd_pulse", cmd_pulse_o, 32'h0);
        checkOutput("rst_mid_cmd_data", cmd_data_o, 32'h0);
        checkOutput("rst_mid_ctrl", ctrl_o, 32'h0);
        checkOutput("rst_mid_irq", irq_o, 32'h0);
        checkOutput("rst_mid_rdata", sys_rdata, 32'h0);
        regRead(15'h0001);
        checkOutput("rst_scratch", sys_rdata, 32'h0000);
        regRead(15'h0004);
        checkOutput("rst_irq_mask", sys_rdata, 32'h0000);
        regRead(15'h0003);
        checkOutput("rst_status", sys_rdata, 32'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
